// File: rtl/cache_arb_if.sv
// cache_arb_if: requester, cache and memory signals of the two-port cache arbiter.
// slave is the arbiter's view; master is the view of the surrounding agents.
interface cache_arb_if #(
    parameter int ADR_W  = 15,
    parameter int DATA_W = 32
);
    logic              req0;
    logic              req1;
    logic [ADR_W-1:0]  adr0;
    logic [ADR_W-1:0]  adr1;
    logic              done0;
    logic              done1;
    logic [DATA_W-1:0] rdata;
    logic [ADR_W-1:0]  c_adr;
    logic              c_hit;
    logic [DATA_W-1:0] c_rdata;
    logic              c_wr;
    logic              m_rd;
    logic              m_ready;
    logic [12:0]       hit_cnt;
    logic [12:0]       miss_cnt;

    modport slave (
        input  req0, req1, adr0, adr1, c_hit, c_rdata, m_ready,
        output done0, done1, rdata, c_adr, c_wr, m_rd, hit_cnt, miss_cnt
    );

    modport master (
        output req0, req1, adr0, adr1, c_hit, c_rdata, m_ready,
        input  done0, done1, rdata, c_adr, c_wr, m_rd, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/cache_arb.sv
// cache_arb: round-robin arbiter giving two read requesters access to a cache with memory refill.
// Define CACHE_ARB_STATS_EN to build the saturating first-lookup hit/miss counters.
module cache_arb #(
    parameter int ADR_W  = 15,
    parameter int DATA_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    cache_arb_if.slave bus_io
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOOKUP = 2'd1;
    localparam logic [1:0] FILL   = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              idx_q, idx_d;
    logic              last_q, last_d;
    logic              refill_q, refill_d;
    logic [ADR_W-1:0]  adr_q, adr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              gnt;

    // Port 1 wins when it alone requests, or on a tie when port 0 was served last.
    assign gnt = bus_io.req1 & (~bus_io.req0 | ~last_q);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        last_d   = last_q;
        refill_d = refill_q;
        adr_d    = adr_q;
        rdata_d  = rdata_q;
        case (state_q)
            IDLE: begin
                if (bus_io.req0 | bus_io.req1) begin
                    idx_d    = gnt;
                    last_d   = gnt;
                    adr_d    = gnt ? bus_io.adr1 : bus_io.adr0;
                    refill_d = 1'b0;
                    state_d  = LOOKUP;
                end
            end
            LOOKUP: begin
                rdata_d = bus_io.c_hit ? bus_io.c_rdata : rdata_q;
                state_d = bus_io.c_hit ? RESP : FILL;
            end
            FILL: begin
                refill_d = bus_io.m_ready ? 1'b1 : refill_q;
                state_d  = bus_io.m_ready ? LOOKUP : FILL;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= 1'b0;
            last_q   <= 1'b1;
            refill_q <= 1'b0;
            adr_q    <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            refill_q <= refill_d;
            adr_q    <= adr_d;
            rdata_q  <= rdata_d;
        end
    end

    assign bus_io.done0 = (state_q == RESP) & ~idx_q;
    assign bus_io.done1 = (state_q == RESP) & idx_q;
    assign bus_io.rdata = rdata_q;
    assign bus_io.c_adr = adr_q;
    assign bus_io.m_rd  = (state_q == FILL);
    assign bus_io.c_wr  = (state_q == FILL) & bus_io.m_ready;

`ifdef CACHE_ARB_STATS_EN
    logic [12:0] hit_q, miss_q;
    logic        hit_ev, miss_ev;

    // Only the first lookup of a transaction is a genuine hit or miss.
    assign hit_ev  = (state_q == LOOKUP) & ~refill_q & bus_io.c_hit;
    assign miss_ev = (state_q == LOOKUP) & ~refill_q & ~bus_io.c_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            if (hit_ev && hit_q != 13'h1fff)
                hit_q <= hit_q + 13'd1;
            if (miss_ev && miss_q != 13'h1fff)
                miss_q <= miss_q + 13'd1;
        end
    end

    assign bus_io.hit_cnt  = hit_q;
    assign bus_io.miss_cnt = miss_q;
`else
    assign bus_io.hit_cnt  = '0;
    assign bus_io.miss_cnt = '0;
`endif
endmodule

// File: tb/tb_cache_arb.sv
// tb_cache_arb: randomized requesters, cache and memory around cache_arb, checked
// against a transaction-level model of grant order, latency, data and statistics.
module tb_cache_arb;
    localparam int ADR_W  = 15;
    localparam int DATA_W = 32;
`ifdef CACHE_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   last_m = 1;
    int   exp_hit = 0;
    int   exp_miss = 0;
    int   got_port;
    bit   valid [0:(1<<ADR_W)-1];

    cache_arb_if #(.ADR_W(ADR_W), .DATA_W(DATA_W)) bus ();

    cache_arb #(.ADR_W(ADR_W), .DATA_W(DATA_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] word_of(input logic [ADR_W-1:0] a);
        return 32'hA5A5_A5A5 ^ ({17'd0, a} * 32'h9E37_79B1);
    endfunction

    function automatic logic [ADR_W-1:0] rand_adr();
        return ADR_W'(1000 + $urandom_range(0, 31));
    endfunction

    // Cache model: hit flag and word for whatever address the arbiter drives.
    always @(negedge clk) begin
        bus.c_hit   = valid[bus.c_adr];
        bus.c_rdata = word_of(bus.c_adr);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge while the arbiter idles with at least one req high.
    task automatic run_txn(input bit force_hit, input bit keep, output int port);
        int w, nf, lat, exp_lat, exp_mrd, mrd_n, wr_n, fi, fcnt;
        int flen [3];
        logic [ADR_W-1:0] a;
        bit first_hit;
        w = (bus.req0 && bus.req1) ? 1 - last_m : (bus.req1 ? 1 : 0);
        last_m = w;
        a = w ? bus.adr1 : bus.adr0;
        if (force_hit)
            valid[a] = 1'b1;
        first_hit = valid[a];
        nf = first_hit ? 0 : $urandom_range(1, 3);
        exp_lat = 2;
        exp_mrd = 0;
        for (int i = 0; i < nf; i++) begin
            flen[i] = $urandom_range(1, 4);
            exp_lat += flen[i] + 1;
            exp_mrd += flen[i];
        end
        lat = 0; mrd_n = 0; wr_n = 0; fi = 0; fcnt = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1 && !keep && $urandom_range(0, 3) == 0) begin
                if (w == 1) bus.req1 = 1'b0;
                else        bus.req0 = 1'b0;
            end
            bus.m_ready = 1'b0;
            if (bus.m_rd) begin
                mrd_n++;
                fcnt++;
                if (fi < nf && fcnt == flen[fi]) begin
                    bus.m_ready = 1'b1;
                    valid[a] = (fi == nf - 1);
                    fi++;
                    fcnt = 0;
                end
            end
            #1;
            if (bus.c_wr) wr_n++;
            check("done_excl", bus.done0 & bus.done1, 0);
        end while (!(bus.done0 || bus.done1) && lat < 100);
        port = bus.done1 ? 1 : 0;
        check("latency", lat, exp_lat);
        check("done_port", bus.done1, w);
        check("rdata", bus.rdata, word_of(a));
        check("m_rd_cycles", mrd_n, exp_mrd);
        check("c_wr_pulses", wr_n, nf);
        if (STATS && first_hit && exp_hit < 8191)   exp_hit++;
        if (STATS && !first_hit && exp_miss < 8191) exp_miss++;
        check("hit_cnt", bus.hit_cnt, exp_hit);
        check("miss_cnt", bus.miss_cnt, exp_miss);
        if (!keep) begin
            if (w == 1) bus.req1 = 1'b0;
            else        bus.req0 = 1'b0;
        end
        @(negedge clk);
        check("done_one_cycle", bus.done0 | bus.done1, 0);
        check("m_rd_idle", bus.m_rd, 0);
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_m = 1;
        exp_hit = 0;
        exp_miss = 0;
    endtask

    initial begin
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.adr0 = '0;   bus.adr1 = '0;
        bus.m_ready = 1'b0;
        bus.c_hit = 1'b0; bus.c_rdata = '0;
        #1 rst = 1'b1;
        #1;
        check("rst_done0", bus.done0, 0);
        check("rst_done1", bus.done1, 0);
        check("rst_m_rd", bus.m_rd, 0);
        check("rst_c_wr", bus.c_wr, 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_c_adr", bus.c_adr, 0);
        check("rst_hit_cnt", bus.hit_cnt, 0);
        check("rst_miss_cnt", bus.miss_cnt, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Random mix of single requests, ties, hits, misses and repeated refills.
        for (int t = 0; t < 300; t++) begin
            if (!bus.req0 && $urandom_range(0, 1) == 1) begin
                bus.req0 = 1'b1;
                bus.adr0 = rand_adr();
            end
            if (!bus.req1 && $urandom_range(0, 1) == 1) begin
                bus.req1 = 1'b1;
                bus.adr1 = rand_adr();
            end
            if ($urandom_range(0, 3) == 0)
                valid[rand_adr()] = 1'b0;
            if (!bus.req0 && !bus.req1) begin
                @(negedge clk);
                check("idle_done", bus.done0 | bus.done1, 0);
                check("idle_m_rd", bus.m_rd, 0);
            end else begin
                run_txn(1'b0, 1'b0, got_port);
            end
        end

        // Reset while refilling abandons the transaction.
        bus.req0 = 1'b0;
        bus.req1 = 1'b1;
        bus.adr1 = ADR_W'(1004);
        valid[1004] = 1'b0;
        for (int i = 0; i < 20 && !bus.m_rd; i++)
            @(negedge clk);
        check("fill_reached", bus.m_rd, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstfill_m_rd", bus.m_rd, 0);
        check("rstfill_c_wr", bus.c_wr, 0);
        check("rstfill_done", bus.done0 | bus.done1, 0);
        check("rstfill_hit_cnt", bus.hit_cnt, 0);
        check("rstfill_miss_cnt", bus.miss_cnt, 0);
        @(negedge clk);
        check("rstfill_no_done", bus.done0 | bus.done1, 0);
        rst = 1'b0;
        bus.req1 = 1'b0;
        last_m = 1;
        exp_hit = 0;
        exp_miss = 0;
        bus.req0 = 1'b1;
        bus.adr0 = ADR_W'(1000);
        run_txn(1'b0, 1'b0, got_port);
        check("after_rst_port", got_port, 0);

        // Both ports held high with hits alternate starting from port 0.
        reset_pulse();
        bus.req0 = 1'b1; bus.adr0 = ADR_W'(1000);
        bus.req1 = 1'b1; bus.adr1 = ADR_W'(1004);
        for (int i = 0; i < 4; i++) begin
            run_txn(1'b1, 1'b1, got_port);
            check("rr_order", got_port, i % 2);
        end
        bus.req1 = 1'b0;

        // Long run of hits drives the hit counter into saturation.
        for (int i = 0; i < 8200; i++)
            run_txn(1'b1, 1'b1, got_port);
        check("hit_saturated", bus.hit_cnt, STATS ? 8191 : 0);
        check("miss_after_sat", bus.miss_cnt, 0);
        bus.req0 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/cache_arb.md
CACHE_ARB -- requirements
Module: cache_arb

Interface
REQ-001 SHALL have parameter ADR_W, default 15, address width in bits.
REQ-002 SHALL have parameter DATA_W, default 32, read data width in bits.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req0, req1  input  1 each  requester 0/1 read request, held high until the matching done.
REQ-006 adr0, adr1  input  ADR_W each  requester 0/1 word address, stable while the matching req is high.
REQ-007 done0, done1  output  1 each  one-cycle completion pulse to requester 0/1.
REQ-008 rdata  output  DATA_W  read data; valid in the cycle done0 or done1 is high.
REQ-009 c_adr  output  ADR_W  address driven to cache and memory.
REQ-010 c_hit, c_rdata  input  1, DATA_W  cache hit flag and read word for c_adr, combinational from the cache.
REQ-011 c_wr  output  1  cache line refill strobe.
REQ-012 m_rd, m_ready  output, input  1 each  memory block read request and memory data-ready.
REQ-013 hit_cnt, miss_cnt  output  13 each  statistics counters (see Configuration).

Function
REQ-014 SHALL implement FSM states IDLE, LOOKUP, FILL, RESP.
REQ-015 IDLE: no req -> stay; any req -> register winner index and its address into c_adr, go to LOOKUP.
REQ-016 Arbitration SHALL be round-robin: only one request -> grant it; both -> grant the port not served last; last-served pointer updates at each grant.
REQ-017 LOOKUP: c_hit=1 -> capture c_rdata into rdata, go to RESP; c_hit=0 -> go to FILL.
REQ-018 FILL: m_rd=1 every cycle; when m_ready=1, c_wr=1 that same cycle, go to LOOKUP; otherwise stay, with no timeout.
REQ-019 The LOOKUP after FILL SHALL be treated as a refill lookup: its hit is not counted, and a second miss re-enters FILL.
REQ-020 RESP: assert done of the granted port only, for exactly one cycle, go to IDLE.
REQ-021 Hit latency: req sampled at edge N -> done high in cycle N+2. Miss latency: N+2 plus FILL cycles plus 1.
REQ-022 c_adr and granted index SHALL be held constant from grant to end of RESP.
REQ-023 A requester dropping req mid-transaction SHALL NOT abort it; done is still issued. A req still high in the IDLE cycle after RESP is a new request.
REQ-024 The other requester's req SHALL be ignored until the FSM returns to IDLE.
REQ-025 m_rd and c_wr SHALL be 0 outside FILL. done0 and done1 SHALL never be high together.

Reset
REQ-026 rst=1 SHALL force IDLE, done0=done1=0, c_wr=0, m_rd=0, rdata=0, c_adr=0, hit_cnt=miss_cnt=0, and the last-served pointer to port 1, so port 0 wins the first tie.
REQ-027 rst asserted mid-transaction SHALL abandon it with no done issued; operation resumes from IDLE after deassertion.

Configuration
REQ-028 Macro CACHE_ARB_STATS_EN defined: hit_cnt increments on a first-lookup hit; miss_cnt increments on entry to FILL from a first lookup.
REQ-029 Both counters SHALL saturate at 8191.
REQ-030 Macro CACHE_ARB_STATS_EN undefined: hit_cnt and miss_cnt SHALL be tied to 0 and no counter flops synthesized.

Verification
REQ-031 req0=1, adr0=1000, c_hit=1, c_rdata=0xA5A5A5A5 -> done0 high 2 cycles after sampling, rdata=0xA5A5A5A5, hit_cnt=1 (STATS_EN).
REQ-032 req1=1, adr1=1004, c_hit=0 until refill, m_ready after 3 cycles of m_rd -> one c_wr pulse, done1 at cycle 6, miss_cnt=1, hit_cnt unchanged.
REQ-033 req0 and req1 held high, all hits -> done order 0,1,0,1; no cycle has both dones high.
REQ-034 rst pulsed while in FILL -> m_rd drops immediately, no done, counters 0; after release req0 alone completes normally.
REQ-035 8200 consecutive hits with STATS_EN -> hit_cnt=8191; same run without the macro -> hit_cnt=miss_cnt=0 throughout.
